// File: rtl/matmult_nxn_seq.sv
// matmult_nxn_seq: NxN signed matrix multiply, optional accumulate of C_in, on one sequential MAC.
// Define MATMULT_SATURATE_EN to clamp each result element to DATA_W instead of wrapping.
module matmult_nxn_seq #(
  parameter int N      = 2,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  matmult_ready,
  input  logic                  matmult_accept,
  output logic                  matmult_valid,
  output logic                  matmult_busy,
  input  logic                  matmult_in_acc,
  input  logic [N*N*DATA_W-1:0] matmult_in_a,
  input  logic [N*N*DATA_W-1:0] matmult_in_b,
  input  logic [N*N*DATA_W-1:0] matmult_in_c,
  output logic [N*N*DATA_W-1:0] matmult_out_c
);
  // state | meaning
  // IDLE  | waiting for matmult_ready
  // CALC  | one MAC per edge, walking i, j, k
  // FIN   | result valid and held until matmult_accept

  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2*DATA_W + $clog2(N) + 1;
  localparam int MW    = N*N*DATA_W;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t                    state;
  logic [MW-1:0]             a_q, b_q, c_q, res_q, res_next;
  logic                      acc_mode;
  logic [IW-1:0]             i_q, j_q, k_q;
  logic signed [ACC_W-1:0]   acc_q, acc_next;
  logic signed [DATA_W-1:0]  a_el, b_el, c_el, elem;
  logic signed [2*DATA_W-1:0] prod;
  logic                      k_last, j_last, i_last;

`ifdef MATMULT_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  always_comb begin
    k_last = (int'(k_q) == N-1);
    j_last = (int'(j_q) == N-1);
    i_last = (int'(i_q) == N-1);
    a_el = a_q[(int'(i_q)*N + int'(k_q))*DATA_W +: DATA_W];
    b_el = b_q[(int'(k_q)*N + int'(j_q))*DATA_W +: DATA_W];
    c_el = c_q[(int'(i_q)*N + int'(j_q))*DATA_W +: DATA_W];
    prod = $signed({{DATA_W{a_el[DATA_W-1]}}, a_el}) * $signed({{DATA_W{b_el[DATA_W-1]}}, b_el});
    if (k_q == '0)
      acc_next = ACC_W'(prod) + (acc_mode ? ACC_W'(c_el) : '0);
    else
      acc_next = acc_q + ACC_W'(prod);
`ifdef MATMULT_SATURATE_EN
    if (acc_next > SAT_MAX)
      elem = SAT_MAX[DATA_W-1:0];
    else if (acc_next < SAT_MIN)
      elem = SAT_MIN[DATA_W-1:0];
    else
      elem = acc_next[DATA_W-1:0];
`else
    elem = acc_next[DATA_W-1:0];
`endif
    // Buffer with the current element merged, so the final edge can publish everything at once.
    res_next = res_q;
    res_next[(int'(i_q)*N + int'(j_q))*DATA_W +: DATA_W] = elem;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      res_q         <= '0;
      acc_mode      <= 1'b0;
      acc_q         <= '0;
      i_q           <= '0;
      j_q           <= '0;
      k_q           <= '0;
      matmult_out_c <= '0;
      matmult_valid <= 1'b0;
      matmult_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          matmult_valid <= 1'b0;
          if (matmult_ready) begin
            a_q          <= matmult_in_a;
            b_q          <= matmult_in_b;
            c_q          <= matmult_in_c;
            acc_mode     <= matmult_in_acc;
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            matmult_busy <= 1'b1;
            state        <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_next;
          if (k_last) begin
            res_q <= res_next;
            k_q   <= '0;
            if (j_last) begin
              j_q <= '0;
              if (i_last) begin
                i_q           <= '0;
                matmult_out_c <= res_next;
                matmult_valid <= 1'b1;
                state         <= FIN;
              end else begin
                i_q <= i_q + 1'b1;
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        FIN: begin
          if (matmult_accept) begin
            matmult_valid <= 1'b0;
            matmult_busy  <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmult_nxn_seq.sv
// Bench for matmult_nxn_seq: three instances (2x2/64b, 2x2/8b, 3x3/16b) against a plain-arithmetic model.
module tb_matmult_nxn_seq;
`ifdef MATMULT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic rdy0 = 0, rdy1 = 0, rdy2 = 0;
  logic acpt0 = 0, acpt1 = 0, acpt2 = 0;
  logic am0 = 0, am1 = 0, am2 = 0;
  logic val0, val1, val2, bsy0, bsy1, bsy2;
  logic [255:0] a0 = '0, b0 = '0, c0 = '0, o0;
  logic [31:0]  a1 = '0, b1 = '0, c1 = '0, o1;
  logic [143:0] a2 = '0, b2 = '0, c2 = '0, o2;

  matmult_nxn_seq #(.N(2), .DATA_W(64)) u_dut0 (
    .clk(clk), .rst(rst), .matmult_ready(rdy0), .matmult_accept(acpt0),
    .matmult_valid(val0), .matmult_busy(bsy0), .matmult_in_acc(am0),
    .matmult_in_a(a0), .matmult_in_b(b0), .matmult_in_c(c0), .matmult_out_c(o0));

  matmult_nxn_seq #(.N(2), .DATA_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .matmult_ready(rdy1), .matmult_accept(acpt1),
    .matmult_valid(val1), .matmult_busy(bsy1), .matmult_in_acc(am1),
    .matmult_in_a(a1), .matmult_in_b(b1), .matmult_in_c(c1), .matmult_out_c(o1));

  matmult_nxn_seq #(.N(3), .DATA_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .matmult_ready(rdy2), .matmult_accept(acpt2),
    .matmult_valid(val2), .matmult_busy(bsy2), .matmult_in_acc(am2),
    .matmult_in_a(a2), .matmult_in_b(b2), .matmult_in_c(c2), .matmult_out_c(o2));

  int total = 0;
  int bad   = 0;
  longint ma[9], mb[9], mc[9], expv[9];

  function automatic int dim(input int s);
    return (s == 2) ? 3 : 2;
  endfunction

  function automatic int wid(input int s);
    return (s == 0) ? 64 : ((s == 1) ? 8 : 16);
  endfunction

  function automatic longint fit(input longint v, input int w);
    longint lim, m;
    if (w >= 64) return v;
    lim = longint'(1) <<< (w-1);
    if (SAT) begin
      if (v > lim-1) return lim-1;
      if (v < -lim) return -lim;
      return v;
    end
    m = v & ((lim <<< 1) - 1);
    if (m >= lim) m = m - (lim <<< 1);
    return m;
  endfunction

  // Reference: C[i][j] = (acc ? C_in[i][j] : 0) + sum_k A[i][k]*B[k][j], then fitted to the element width.
  function automatic void model(input int s, input bit am);
    int n;
    longint sum;
    n = dim(s);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        sum = am ? mc[i*n+j] : 0;
        for (int k = 0; k < n; k++) sum += ma[i*n+k] * mb[k*n+j];
        expv[i*n+j] = fit(sum, wid(s));
      end
  endfunction

  function automatic logic get_valid(input int s);
    return (s == 0) ? val0 : ((s == 1) ? val1 : val2);
  endfunction

  function automatic logic get_busy(input int s);
    return (s == 0) ? bsy0 : ((s == 1) ? bsy1 : bsy2);
  endfunction

  function automatic longint get_out(input int s, input int idx);
    case (s)
      0:       return longint'($signed(o0[idx*64 +: 64]));
      1:       return longint'($signed(o1[idx*8 +: 8]));
      default: return longint'($signed(o2[idx*16 +: 16]));
    endcase
  endfunction

  task automatic set_rdy(input int s, input logic v);
    case (s) 0: rdy0 = v; 1: rdy1 = v; default: rdy2 = v; endcase
  endtask

  task automatic set_acpt(input int s, input logic v);
    case (s) 0: acpt0 = v; 1: acpt1 = v; default: acpt2 = v; endcase
  endtask

  task automatic load(input int s, input bit am);
    for (int e = 0; e < 9; e++) begin
      case (s)
        0: if (e < 4) begin
          a0[e*64 +: 64] = ma[e]; b0[e*64 +: 64] = mb[e]; c0[e*64 +: 64] = mc[e];
        end
        1: if (e < 4) begin
          a1[e*8 +: 8] = ma[e][7:0]; b1[e*8 +: 8] = mb[e][7:0]; c1[e*8 +: 8] = mc[e][7:0];
        end
        default: begin
          a2[e*16 +: 16] = ma[e][15:0]; b2[e*16 +: 16] = mb[e][15:0]; c2[e*16 +: 16] = mc[e][15:0];
        end
      endcase
    end
    case (s) 0: am0 = am; 1: am1 = am; default: am2 = am; endcase
  endtask

  // Inputs are only meaningful on the latching edge; disturb them afterwards.
  task automatic scramble(input int s);
    case (s)
      0: begin a0 = ~a0; b0 = ~b0; c0 = ~c0; am0 = ~am0; end
      1: begin a1 = ~a1; b1 = ~b1; c1 = ~c1; am1 = ~am1; end
      default: begin a2 = ~a2; b2 = ~b2; c2 = ~c2; am2 = ~am2; end
    endcase
  endtask

  task automatic run_job(input int s, input bit am, input bit acpt_calc,
                         output int lat, output bit busy_ok);
    int n3;
    n3 = dim(s) * dim(s) * dim(s);
    @(negedge clk);
    load(s, am);
    set_rdy(s, 1'b1);
    @(posedge clk);
    #1;
    set_rdy(s, 1'b0);
    scramble(s);
    busy_ok = get_busy(s);
    if (acpt_calc) set_acpt(s, 1'b1);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (acpt_calc && lat == n3-1) set_acpt(s, 1'b0);
      if (get_valid(s)) break;
      if (!get_busy(s)) busy_ok = 1'b0;
    end
    set_acpt(s, 1'b0);
    if (!get_busy(s)) busy_ok = 1'b0;
    model(s, am);
  endtask

  task automatic accept_job(input int s);
    @(negedge clk);
    set_acpt(s, 1'b1);
    @(posedge clk);
    #1;
    set_acpt(s, 1'b0);
  endtask

  task automatic rand_mats(input int w);
    for (int e = 0; e < 9; e++) begin
      ma[e] = longint'($urandom_range(0, (1 << w) - 1)) - (longint'(1) <<< (w-1));
      mb[e] = longint'($urandom_range(0, (1 << w) - 1)) - (longint'(1) <<< (w-1));
      mc[e] = longint'($urandom_range(0, (1 << w) - 1)) - (longint'(1) <<< (w-1));
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({val0, val1, val2} !== 3'b000) begin
      bad++; $display("FAIL reset_valid got=%b exp=000", {val0, val1, val2});
    end
    total++;
    if ({bsy0, bsy1, bsy2} !== 3'b000) begin
      bad++; $display("FAIL reset_busy got=%b exp=000", {bsy0, bsy1, bsy2});
    end
    total++;
    if (o0 !== '0 || o1 !== '0 || o2 !== '0) begin
      bad++; $display("FAIL reset_out got=%h/%h/%h exp=0", o0, o1, o2);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_job(input string name, input int s, input bit am, input bit acpt_calc);
    int lat, n;
    bit bok;
    n = dim(s);
    run_job(s, am, acpt_calc, lat, bok);
    total++;
    if (lat !== n*n*n) begin
      bad++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, n*n*n);
    end
    total++;
    if (!bok) begin
      bad++; $display("FAIL %s busy got=0 exp=1 during job", name);
    end
    for (int e = 0; e < n*n; e++) begin
      total++;
      if (get_out(s, e) !== expv[e]) begin
        bad++; $display("FAIL %s elem%0d got=%0d exp=%0d", name, e, get_out(s, e), expv[e]);
      end
    end
    accept_job(s);
    total++;
    if (get_valid(s) !== 1'b0 || get_busy(s) !== 1'b0) begin
      bad++; $display("FAIL %s accept valid=%b busy=%b exp=0/0", name, get_valid(s), get_busy(s));
    end
  endtask

  task automatic basic_mats();
    ma = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    mb = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    mc = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
  endtask

  task automatic test_basic();
    basic_mats();
    test_job("basic", 0, 1'b0, 1'b0);
    total++;
    if (get_out(0, 0) !== 64'sd19 || get_out(0, 3) !== 64'sd50) begin
      bad++; $display("FAIL basic_const got=%0d,%0d exp=19,50", get_out(0, 0), get_out(0, 3));
    end
  endtask

  task automatic test_accumulate();
    basic_mats();
    mc = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    test_job("acc_on", 0, 1'b1, 1'b0);
    test_job("acc_off", 0, 1'b0, 1'b0);
  endtask

  task automatic test_signed();
    ma = '{-1, 2, -3, 4, 0, 0, 0, 0, 0};
    mb = '{5, -6, 7, 8, 0, 0, 0, 0, 0};
    mc = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    test_job("signed_acpt_in_calc", 0, 1'b0, 1'b1);
  endtask

  task automatic test_handshake();
    int lat;
    logic [255:0] expp;
    basic_mats();
    model(0, 1'b0);
    for (int e = 0; e < 4; e++) expp[e*64 +: 64] = expv[e];
    @(negedge clk);
    load(0, 1'b0);
    rdy0 = 1'b1;
    @(posedge clk);
    #1;
    scramble(0);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); lat++; #1;
      if (val0) break;
    end
    total++;
    if (lat !== 8) begin
      bad++; $display("FAIL hs_latency got=%0d exp=8", lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (val0 !== 1'b1 || o0 !== expp) begin
        bad++; $display("FAIL hs_hold cyc%0d valid=%b out=%h exp=%h", c, val0, o0, expp);
      end
    end
    load(0, 1'b0);
    acpt0 = 1'b1;
    @(posedge clk);
    #1;
    acpt0 = 1'b0;
    total++;
    if (val0 !== 1'b0 || bsy0 !== 1'b0) begin
      bad++; $display("FAIL hs_accept valid=%b busy=%b exp=0/0", val0, bsy0);
    end
    @(posedge clk);
    #1;
    rdy0 = 1'b0;
    scramble(0);
    total++;
    if (bsy0 !== 1'b1) begin
      bad++; $display("FAIL hs_relatch busy=%b exp=1", bsy0);
    end
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); lat++; #1;
      if (val0) break;
    end
    total++;
    if (lat !== 8 || o0 !== expp) begin
      bad++; $display("FAIL hs_second lat=%0d out=%h exp=8/%h", lat, o0, expp);
    end
    accept_job(0);
    total++;
    if (val0 !== 1'b0) begin
      bad++; $display("FAIL hs_final_accept valid=%b exp=0", val0);
    end
  endtask

  task automatic test_reset_mid();
    basic_mats();
    @(negedge clk);
    load(0, 1'b0);
    rdy0 = 1'b1;
    @(posedge clk);
    #1;
    rdy0 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (val0 !== 1'b0 || bsy0 !== 1'b0) begin
      bad++; $display("FAIL midreset_flags valid=%b busy=%b exp=0/0", val0, bsy0);
    end
    total++;
    if (o0 !== '0) begin
      bad++; $display("FAIL midreset_out got=%h exp=0", o0);
    end
    @(negedge clk);
    rst = 1'b1;
    basic_mats();
    test_job("after_reset", 0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    ma = '{100, 0, 0, 0, 0, 0, 0, 0, 0};
    mb = '{100, 0, 0, 0, 0, 0, 0, 0, 0};
    mc = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    test_job("overflow8", 1, 1'b0, 1'b0);
    for (int t = 0; t < 8; t++) begin
      rand_mats(8);
      test_job("rand8", 1, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_n3();
    for (int e = 0; e < 9; e++) begin
      ma[e] = (e % 4 == 0) ? 1 : 0;
      mb[e] = e + 1;
      mc[e] = 0;
    end
    test_job("identity3", 2, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++) begin
      rand_mats(16);
      test_job("rand3", 2, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_random64();
    for (int t = 0; t < 8; t++) begin
      rand_mats(21);
      test_job("rand64", 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
    test_signed();
    test_handshake();
    test_reset_mid();
    test_overflow();
    test_n3();
    test_random64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
